i2c_bus_extender: RTL and testbench

- Clocked one-to-two I2C fan-out/extender.
- Takes one upstream SCL/SDA pair, re-times it into the system clock domain, and drives a shared SCL plus two identical downstream SDA branches.
- Tracks bus state (START/STOP/busy) so supervisory logic can observe traffic.
- Sits between the board-level I2C master pins and two downstream segments.

---
 rtl/i2c_ext_pkg.sv | 15 +
 rtl/i2c_ext_line_cond.sv | 61 ++++++
 rtl/i2c_bus_extender.sv | 87 ++++++++
 tb/tb_i2c_bus_extender.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_ext_pkg.sv
// Shared constants and helpers for the I2C bus extender.
package i2c_ext_pkg;

    // Level of an idle (released) I2C line.
    localparam logic IDLE_LEVEL = 1'b1;

    // Default glitch-filter length in clk cycles.
    localparam int FILT_LEN_DEFAULT = 4;

    // Width of a counter that must hold values 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/i2c_ext_line_cond.sv
// Line conditioner: 2-flop synchronizer followed by an optional glitch filter.
// The filter is built only when I2C_EXT_GLITCH_FILT_EN is defined; otherwise
// the synchronized level is passed straight through and FILT_LEN is ignored.
module i2c_ext_line_cond
    import i2c_ext_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_line,
    output logic o_line
);

    // Out-of-range lengths stop elaboration instead of building a broken filter.
    if (FILT_LEN < 1 || FILT_LEN > 255) begin : g_bad_filt_len
        $error("i2c_ext_line_cond: FILT_LEN must be within 1..255");
    end

    logic r_s1;
    logic r_s2;

    // Two-stage synchronizer; presets to the idle level so reset looks like a quiet bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= IDLE_LEVEL;
            r_s2 <= IDLE_LEVEL;
        end else begin
            r_s1 <= i_line;
            r_s2 <= r_s1;
        end
    end

`ifdef I2C_EXT_GLITCH_FILT_EN
    localparam int              CNT_W    = cnt_width(FILT_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_filt;

    // Accept a new level only after it has disagreed with the filtered level for FILT_LEN edges in a row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_filt <= IDLE_LEVEL;
            r_cnt  <= '0;
        end else if (r_s2 == r_filt) begin
            r_cnt  <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_filt <= r_s2;
            r_cnt  <= '0;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    assign o_line = r_filt;
`else
    assign o_line = r_s2;
`endif

endmodule

// File: rtl/i2c_bus_extender.sv
// One-to-two I2C extender: re-times upstream SCL/SDA, drives a shared SCL and
// two identical SDA branches, and reports START/STOP/busy from the conditioned
// lines. Define I2C_EXT_GLITCH_FILT_EN to add the FILT_LEN-cycle glitch filter.
module i2c_bus_extender
    import i2c_ext_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_out,
    output logic sda_out1,
    output logic sda_out2,
    output logic bus_busy,
    output logic start_det,
    output logic stop_det
);

    // Index 0 carries SCL, index 1 carries SDA; both lines get identical conditioning
    // so their relative edge order survives.
    logic [1:0] w_line_raw;
    logic [1:0] w_line_f;

    assign w_line_raw = {sda_in, scl_in};

    for (genvar gi = 0; gi < 2; gi++) begin : g_line
        i2c_ext_line_cond #(
            .FILT_LEN (FILT_LEN)
        ) u_cond (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_line (w_line_raw[gi]),
            .o_line (w_line_f[gi])
        );
    end

    logic w_scl_f;
    logic w_sda_f;
    logic w_start;
    logic w_stop;

    logic r_scl_out;
    logic r_sda_out;
    logic r_busy;
    logic r_start;
    logic r_stop;

    assign w_scl_f = w_line_f[0];
    assign w_sda_f = w_line_f[1];

    // The output registers hold the previous filtered level, so they double as
    // the "last cycle" reference for edge detection. SCL must be high on both
    // sides of the SDA edge; a same-cycle SCL change therefore never qualifies.
    assign w_start = r_scl_out & w_scl_f &  r_sda_out & ~w_sda_f;
    assign w_stop  = r_scl_out & w_scl_f & ~r_sda_out &  w_sda_f;

    // Line outputs and bus status update together so status aligns with the SDA edge that caused it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scl_out <= IDLE_LEVEL;
            r_sda_out <= IDLE_LEVEL;
            r_busy    <= 1'b0;
            r_start   <= 1'b0;
            r_stop    <= 1'b0;
        end else begin
            r_scl_out <= w_scl_f;
            r_sda_out <= w_sda_f;
            r_start   <= w_start;
            r_stop    <= w_stop;
            if (w_start) begin
                r_busy <= 1'b1;
            end else if (w_stop) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign scl_out   = r_scl_out;
    assign sda_out1  = r_sda_out;
    assign sda_out2  = r_sda_out;
    assign bus_busy  = r_busy;
    assign start_det = r_start;
    assign stop_det  = r_stop;

endmodule

// File: tb/tb_i2c_bus_extender.sv
// Bench for i2c_bus_extender: directed I2C-like sequences, a cycle-level
// reference model derived from the latency/filter/START/STOP rules, and
// literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_i2c_bus_extender;

    localparam int F = 4;
`ifdef I2C_EXT_GLITCH_FILT_EN
    localparam bit FILT_ON = 1'b1;
    localparam int LAT     = 2 + F;
`else
    localparam bit FILT_ON = 1'b0;
    localparam int LAT     = 2;
`endif
    localparam int HMAX = 8192;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic scl_in = 1'b0;
    logic sda_in = 1'b0;
    logic scl_out, sda_out1, sda_out2, bus_busy, start_det, stop_det;

    i2c_bus_extender #(
        .FILT_LEN (F)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_out   (scl_out),
        .sda_out1  (sda_out1),
        .sda_out2  (sda_out2),
        .bus_busy  (bus_busy),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Input/reset history, one entry per rising edge.
    bit h_scl [HMAX];
    bit h_sda [HMAX];
    bit h_rst [HMAX];
    int cyc = 0;

    // Model state: filtered level after the latest edge, and expected outputs.
    bit m_f_scl   = 1'b1;
    bit m_f_sda   = 1'b1;
    bit m_out_scl = 1'b1;
    bit m_out_sda = 1'b1;
    bit m_busy    = 1'b0;
    bit m_start   = 1'b0;
    bit m_stop    = 1'b0;
    bit m_pscl, m_psda;
    int m_n;

    // Activity observed on the DUT, consumed by the directed checks.
    int   scl_tr    = 0;
    int   start_cnt = 0;
    int   stop_cnt  = 0;
    logic last_scl  = 1'b1;

    function automatic bit rst_at(input int k);
        return (k < 0) ? 1'b1 : h_rst[k];
    endfunction

    function automatic bit in_at(input bit is_sda, input int k);
        if (k < 0) return 1'b1;
        return is_sda ? h_sda[k] : h_scl[k];
    endfunction

    // Synchronized level seen by the logic at edge k: the input two edges earlier,
    // unless a reset in between has forced the idle level.
    function automatic bit s2_seen(input bit is_sda, input int k);
        return (rst_at(k - 1) || rst_at(k - 2)) ? 1'b1 : in_at(is_sda, k - 2);
    endfunction

    // Filtered level after edge n.
    function automatic bit next_f(input bit is_sda, input int n, input bit f_prev);
        if (rst_at(n)) return 1'b1;
        if (!FILT_ON) return rst_at(n - 1) ? 1'b1 : in_at(is_sda, n - 1);
        // A new level is taken once it has been seen on F consecutive non-reset edges.
        for (int j = 0; j < F; j++) begin
            if (rst_at(n - j) || (s2_seen(is_sda, n - j) != s2_seen(is_sda, n)))
                return f_prev;
        end
        return s2_seen(is_sda, n);
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic wait_edges(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Per-edge model update and comparison, sampled 1 ns after the rising edge.
    always @(posedge clk) begin
        m_n = cyc;
        if (m_n >= HMAX) begin
            $display("FAIL history_overflow at cycle %0d: actual=%0d expected<%0d", m_n, m_n, HMAX);
            $fatal(1, "history overflow");
        end
        h_scl[m_n] = scl_in;
        h_sda[m_n] = sda_in;
        h_rst[m_n] = !rst_n;
        cyc = cyc + 1;

        m_pscl = m_out_scl;
        m_psda = m_out_sda;
        m_out_scl = rst_at(m_n) ? 1'b1 : m_f_scl;
        m_out_sda = rst_at(m_n) ? 1'b1 : m_f_sda;
        m_f_scl = next_f(1'b0, m_n, m_f_scl);
        m_f_sda = next_f(1'b1, m_n, m_f_sda);
        m_start = !rst_at(m_n) && m_pscl && m_out_scl &&  m_psda && !m_out_sda;
        m_stop  = !rst_at(m_n) && m_pscl && m_out_scl && !m_psda &&  m_out_sda;
        if (rst_at(m_n))  m_busy = 1'b0;
        else if (m_start) m_busy = 1'b1;
        else if (m_stop)  m_busy = 1'b0;

        #1;
        check_bit("model_scl_out",   scl_out,   m_out_scl);
        check_bit("model_sda_out1",  sda_out1,  m_out_sda);
        check_bit("model_sda_out2",  sda_out2,  m_out_sda);
        check_bit("model_bus_busy",  bus_busy,  m_busy);
        check_bit("model_start_det", start_det, m_start);
        check_bit("model_stop_det",  stop_det,  m_stop);

        if (scl_out !== last_scl) scl_tr++;
        last_scl = scl_out;
        if (start_det === 1'b1) start_cnt++;
        if (stop_det === 1'b1)  stop_cnt++;
    end

    initial begin
        // Reset with both upstream lines low.
        rst_n = 1'b0; scl_in = 1'b0; sda_in = 1'b0;
        wait_edges(3);
        check_bit("rst_scl_out",   scl_out,   1'b1);
        check_bit("rst_sda_out1",  sda_out1,  1'b1);
        check_bit("rst_sda_out2",  sda_out2,  1'b1);
        check_bit("rst_bus_busy",  bus_busy,  1'b0);
        check_bit("rst_start_det", start_det, 1'b0);
        check_bit("rst_stop_det",  stop_det,  1'b0);
        rst_n = 1'b1;
        wait_edges(LAT);
        check_bit("release_scl_before_latency", scl_out, 1'b1);
        wait_edges(1);
        check_bit("release_scl_at_latency", scl_out, 1'b0);
        check_bit("release_sda_at_latency", sda_out1, 1'b0);
        check_int("release_no_start", start_cnt, 0);

        // Go idle: SDA up while SCL low, then SCL up (no STOP).
        sda_in = 1'b1; wait_edges(3);
        scl_in = 1'b1; wait_edges(LAT + 3);

        // SCL toggling with SDA held high.
        scl_tr = 0; start_cnt = 0; stop_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            scl_in = ~scl_in;
            wait_edges(10);
        end
        wait_edges(LAT + 2);
        check_int("toggle_scl_transitions", scl_tr, 10);
        check_bit("toggle_sda_steady", sda_out1, 1'b1);
        check_int("toggle_no_start", start_cnt, 0);

        // START then STOP.
        start_cnt = 0; stop_cnt = 0;
        sda_in = 1'b0; wait_edges(LAT + 3);
        check_int("start_pulse_count", start_cnt, 1);
        check_bit("start_sets_busy", bus_busy, 1'b1);
        sda_in = 1'b1; wait_edges(LAT + 3);
        check_int("stop_pulse_count", stop_cnt, 1);
        check_bit("stop_clears_busy", bus_busy, 1'b0);

        // START, one data bit, repeated START.
        start_cnt = 0; stop_cnt = 0;
        sda_in = 1'b0; wait_edges(8);
        scl_in = 1'b0; wait_edges(8);
        sda_in = 1'b1; wait_edges(8);
        scl_in = 1'b1; wait_edges(8);
        sda_in = 1'b0; wait_edges(LAT + 3);
        check_int("rstart_pulse_count", start_cnt, 2);
        check_int("rstart_no_stop", stop_cnt, 0);
        check_bit("rstart_busy_held", bus_busy, 1'b1);

        // Reset while the bus is busy; master releases the lines meanwhile.
        rst_n = 1'b0; scl_in = 1'b1; sda_in = 1'b1;
        wait_edges(1);
        check_bit("midrst_busy", bus_busy, 1'b0);
        check_bit("midrst_scl",  scl_out,  1'b1);
        check_bit("midrst_sda1", sda_out1, 1'b1);
        check_bit("midrst_sda2", sda_out2, 1'b1);
        wait_edges(2);
        rst_n = 1'b1;
        start_cnt = 0; stop_cnt = 0;
        wait_edges(LAT + 5);
        check_int("midrst_no_spurious_start", start_cnt, 0);
        check_bit("midrst_idle_after_release", bus_busy, 1'b0);
        sda_in = 1'b0; wait_edges(LAT + 3);
        check_int("post_rst_start", start_cnt, 1);
        sda_in = 1'b1; wait_edges(LAT + 3);
        check_int("post_rst_stop", stop_cnt, 1);
        check_bit("post_rst_busy_clear", bus_busy, 1'b0);

`ifdef I2C_EXT_GLITCH_FILT_EN
        // 3-cycle SCL glitch must vanish; a 4-cycle pulse must pass with latency 2+F.
        scl_tr = 0;
        scl_in = 1'b0; wait_edges(3);
        scl_in = 1'b1; wait_edges(LAT + 4);
        check_int("glitch_short_rejected", scl_tr, 0);
        scl_in = 1'b0; wait_edges(4);
        scl_in = 1'b1; wait_edges(2);
        check_bit("glitch_pulse_before_latency", scl_out, 1'b1);
        wait_edges(1);
        check_bit("glitch_pulse_fall", scl_out, 1'b0);
        wait_edges(3);
        check_bit("glitch_pulse_held", scl_out, 1'b0);
        wait_edges(1);
        check_bit("glitch_pulse_rise", scl_out, 1'b1);
        wait_edges(3);
        check_int("glitch_pulse_transitions", scl_tr, 2);
`else
        // Without the filter even a single-cycle pulse reaches the output.
        scl_tr = 0;
        scl_in = 1'b0; wait_edges(1);
        scl_in = 1'b1; wait_edges(LAT + 3);
        check_int("nofilt_short_pulse_passes", scl_tr, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout at cycle %0d: actual=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
